// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Lets N requesters share one W-bit tri-state bus under round-robin
// arbitration. The grant is a registered one-hot vector that drives the
// per-channel tri-state enables directly. Because it is one-hot, two drivers
// can never be enabled in the same cycle. Data passes from din to bus
// combinationally; only the enables are registered.
//
// Optional feature macro: TSBUS_TURNAROUND_EN
//   defined   -> every owner change inserts one all-Z cycle (TURN state)
//   undefined -> a release re-arbitrates on the same edge (zero dead cycles)
//
// Parameters:
//   N      number of requesting channels (2..16)
//   W      data width per channel and bus width
//   SELW   owner index width, ceil(log2(N)) with a minimum of 1
//   BURST  maximum consecutive grant cycles while another channel waits (1..255)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req[N]     level-sensitive request per channel
//   din[N*W]   channel k data on din[k*W +: W]
//   gnt[N]     registered one-hot grant, all zero when there is no owner
//   owner      index of the granted channel, 0 when there is no owner
//   bus[W]     shared tri-state bus, driven by the owner's din, else high-Z
//   bus_valid  high exactly when some gnt bit is high
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SELW  = 2,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] owner,
  output tri   [W-1:0]    bus,
  output logic            bus_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            bus_valid_q, bus_valid_d;

  // Requests visible to the arbiter. While an owner holds the bus its own
  // request is masked out, so a burst-limit release always hands over to a
  // different channel. On a release caused by the owner dropping req, the
  // owner's bit is zero anyway, so the mask changes nothing there.
  logic [N-1:0]    arb_req;
  logic            arb_found;
  logic [SELW-1:0] arb_idx;
  logic [SELW-1:0] arb_next_ptr;

  always_comb begin
    arb_req = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
  end

  // Rotating search: start at ptr and walk upward modulo N; the first set
  // bit wins.
  always_comb begin
    int probe;
    probe     = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int off = 0; off < N; off++) begin
      probe = int'(ptr_q) + off;
      if (probe >= N) probe = probe - N;
      if (!arb_found && arb_req[probe]) begin
        arb_found = 1'b1;
        arb_idx   = SELW'(probe);
      end
    end
    arb_next_ptr = (arb_idx == SELW'(N - 1)) ? '0 : arb_idx + SELW'(1);
  end

  // Next-state logic.
  always_comb begin
    logic grab;
    logic own_req;
    logic others_req;
    logic at_limit;

    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grab       = 1'b0;
    own_req    = |(req & gnt_q);
    others_req = |(req & ~gnt_q);
    at_limit   = (cnt_q == 8'(BURST));

    case (state_q)
      ST_IDLE, ST_TURN: grab = 1'b1;
      ST_GRANT: begin
        if (!own_req || (at_limit && others_req)) begin
`ifdef TSBUS_TURNAROUND_EN
          state_d = ST_TURN;
          gnt_d   = '0;
          owner_d = '0;
          cnt_d   = '0;
`else
          grab    = 1'b1;
`endif
        end else begin
          // A sole requester keeps the bus; the counter simply wraps.
          cnt_d = at_limit ? 8'd1 : cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (grab) begin
      if (arb_found) begin
        state_d = ST_GRANT;
        gnt_d   = N'(1) << arb_idx;
        owner_d = arb_idx;
        ptr_d   = arb_next_ptr;
        cnt_d   = 8'd1;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    end

    bus_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  // One tri-state buffer per channel, enabled by its own grant bit.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_drv
      assign bus = gnt_q[gi] ? din[gi*W +: W] : {W{1'bz}};
    end
  endgenerate

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign bus_valid = bus_valid_q;

endmodule
